// File: rtl/gesture_pkg.sv
// Shared types and sizing for the gesture pipeline.
// Image geometry defaults, coordinate/sum widths and the profiler state enum.
package gesture_pkg;

  localparam int IMG_W_DEF   = 160;
  localparam int IMG_H_DEF   = 120;
  localparam int MIN_PIX_DEF = 64;

  function automatic int cnt_w(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  function automatic int sum_w(input int span, input int w, input int h);
    return $clog2((span - 1) * w * h + 1);
  endfunction

  localparam int X_W  = $clog2(IMG_W_DEF);
  localparam int Y_W  = $clog2(IMG_H_DEF);
  localparam int C_W  = cnt_w(IMG_W_DEF, IMG_H_DEF);
  localparam int SX_W = sum_w(IMG_W_DEF, IMG_W_DEF, IMG_H_DEF);
  localparam int SY_W = sum_w(IMG_H_DEF, IMG_W_DEF, IMG_H_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/mask_profiler_if.sv
// Mask pixel stream in, per-frame profile out.
// master drives pixels and reads results; slave is the profiler.
interface mask_profiler_if
  import gesture_pkg::*;
#(
  parameter int XW  = X_W,
  parameter int YW  = Y_W,
  parameter int CW  = C_W,
  parameter int SXW = SX_W,
  parameter int SYW = SY_W
);

  logic           object_image;
  logic           pix_valid;
  logic           sof;
  logic [XW-1:0]  min_x;
  logic [XW-1:0]  max_x;
  logic [YW-1:0]  min_y;
  logic [YW-1:0]  max_y;
  logic [CW-1:0]  pix_count;
  logic [SXW-1:0] sum_x;
  logic [SYW-1:0] sum_y;
  logic           obj_present;
  logic           result_valid;
  logic           frame_err;

  modport master (
    output object_image, pix_valid, sof,
    input  min_x, max_x, min_y, max_y,
    input  pix_count, sum_x, sum_y,
    input  obj_present, result_valid, frame_err
  );

  modport slave (
    input  object_image, pix_valid, sof,
    output min_x, max_x, min_y, max_y,
    output pix_count, sum_x, sum_y,
    output obj_present, result_valid, frame_err
  );

endinterface

// File: rtl/raster_counter.sv
// Raster x/y position tracker for a pixel stream.
// x/y give the coordinate of the pixel on the inputs now; sof forces (0,0).
module raster_counter #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] xc;
  logic [YW-1:0] yc;
  logic          x_end;

  assign x     = clr ? '0 : xc;
  assign y     = clr ? '0 : yc;
  assign x_end = (x == XW'(IMG_W - 1));
  assign last  = x_end && (y == YW'(IMG_H - 1));

  // step to the next raster position on each accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xc <= '0;
      yc <= '0;
    end else if (en) begin
      if (x_end) begin
        xc <= '0;
        yc <= last ? '0 : y + YW'(1);
      end else begin
        xc <= x + XW'(1);
        yc <= y;
      end
    end
  end

endmodule

// File: rtl/mask_profiler.sv
// Reduces a 1-bit object mask frame to bounding box, count and sums.
// Accumulates on the fly; no frame storage.
module mask_profiler
  import gesture_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int MIN_PIX = MIN_PIX_DEF
) (
  input logic           clk,
  input logic           rst,
  mask_profiler_if.slave bus
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int CW  = cnt_w(IMG_W, IMG_H);
  localparam int SXW = sum_w(IMG_W, IMG_W, IMG_H);
  localparam int SYW = sum_w(IMG_H, IMG_W, IMG_H);

  typedef struct packed {
    logic [XW-1:0]  min_x;
    logic [XW-1:0]  max_x;
    logic [YW-1:0]  min_y;
    logic [YW-1:0]  max_y;
    logic [CW-1:0]  cnt;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
  } acc_t;

  // empty box is min all-ones, max zero, so min>max means no object
  localparam acc_t ACC_EMPTY = {
    {XW{1'b1}}, {XW{1'b0}},
    {YW{1'b1}}, {YW{1'b0}},
    {(CW + SXW + SYW){1'b0}}
  };

  state_t        state;
  state_t        state_nx;
  logic          start;
  logic          take;
  logic          last;
  logic          done;
  logic          err;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  acc_t          acc;
  acc_t          base;
  acc_t          nxt;
  acc_t          res;
  logic          obj;
  logic          rv;
  logic          fe;

  assign start = bus.pix_valid & bus.sof;
  assign take  = start | (bus.pix_valid & (state == ACCUM));

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .en   (take),
    .clr  (bus.sof),
    .x    (px),
    .y    (py),
    .last (last)
  );

  // fold the current pixel into the running frame profile
  always_comb begin
    base = bus.sof ? ACC_EMPTY : acc;
    nxt  = base;
    if (bus.object_image) begin
      if (px < base.min_x) nxt.min_x = px;
      if (px > base.max_x) nxt.max_x = px;
      if (py < base.min_y) nxt.min_y = py;
      if (py > base.max_y) nxt.max_y = py;
      nxt.cnt = base.cnt + CW'(1);
      nxt.sx  = base.sx + SXW'(px);
      nxt.sy  = base.sy + SYW'(py);
    end
  end

  // running accumulators advance only on accepted pixels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= ACC_EMPTY;
    else if (take) acc <= nxt;
  end

  // frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  // frame sequencing: start on sof, finish on last pixel, abort on early sof
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = ACCUM;
      end
      ACCUM: begin
        if (bus.pix_valid) begin
          if (bus.sof) begin
            err = 1'b1;
          end else if (last) begin
            done     = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = start ? ACCUM : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // publish results with the last pixel included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res <= ACC_EMPTY;
      obj <= 1'b0;
      rv  <= 1'b0;
      fe  <= 1'b0;
    end else begin
      rv <= done;
      fe <= err;
      if (done) begin
        res <= nxt;
        obj <= (nxt.cnt >= CW'(MIN_PIX));
      end
    end
  end

  assign bus.min_x        = res.min_x;
  assign bus.max_x        = res.max_x;
  assign bus.min_y        = res.min_y;
  assign bus.max_y        = res.max_y;
  assign bus.pix_count    = res.cnt;
  assign bus.sum_x        = res.sx;
  assign bus.sum_y        = res.sy;
  assign bus.obj_present  = obj;
  assign bus.result_valid = rv;
  assign bus.frame_err    = fe;

endmodule

// File: tb/tb_mask_profiler.sv
// Bench for mask_profiler: frame-level stimulus against a
// coordinate-list reference model of the profile.
module tb_mask_profiler;
  import gesture_pkg::*;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  localparam logic [89:0] RST_VEC =
    {8'd255, 8'd0, 7'd127, 7'd0, 15'd0, 22'd0, 22'd0, 1'b0};
  localparam logic [89:0] BLOCK_VEC =
    {8'd40, 8'd49, 7'd30, 7'd39, 15'd100, 22'd4450, 22'd3450, 1'b1};
  localparam logic [89:0] SINGLE_VEC =
    {8'd159, 8'd159, 7'd119, 7'd119, 15'd1, 22'd159, 22'd119, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_pass = 0;
  int n_chk  = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;

  int m_mnx, m_mxx, m_mny, m_mxy, m_cnt, m_sx, m_sy;
  logic [89:0] last_vec = RST_VEC;

  mask_profiler_if bus ();

  mask_profiler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) rv_cnt++;
    if (bus.frame_err === 1'b1) fe_cnt++;
  end

  function automatic logic [89:0] got();
    return {bus.min_x, bus.max_x, bus.min_y, bus.max_y,
            bus.pix_count, bus.sum_x, bus.sum_y, bus.obj_present};
  endfunction

  function automatic logic [89:0] want();
    return {8'(m_mnx), 8'(m_mxx), 7'(m_mny), 7'(m_mxy),
            15'(m_cnt), 22'(m_sx), 22'(m_sy),
            (m_cnt >= 64) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_clear();
    m_mnx = 255; m_mny = 127;
    m_mxx = 0;   m_mxy = 0;
    m_cnt = 0;   m_sx = 0; m_sy = 0;
  endtask

  task automatic model_add(input int x, input int y);
    m_cnt++;
    m_sx += x;
    m_sy += y;
    if (x < m_mnx) m_mnx = x;
    if (x > m_mxx) m_mxx = x;
    if (y < m_mny) m_mny = y;
    if (y > m_mxy) m_mxy = y;
  endtask

  function automatic bit pix_on(input int mode, input int x, input int y);
    case (mode)
      1: return (x >= 40 && x <= 49 && y >= 30 && y <= 39);
      2: return (x == 159 && y == 119);
      3: return ($urandom_range(3) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    bus.object_image = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // drives one frame; leaves the last pixel on the bus
  task automatic send_frame(input int mode, input int gap_pct,
                            input int abort_at, input bit now);
    int idx;
    int n;
    bit chk_err;
    bit on;
    idx = 0;
    n = 0;
    chk_err = 1'b0;
    model_clear();
    while (idx < NPIX) begin
      if (!(n == 0 && now)) @(negedge clk);
      if (chk_err) begin
        chk_err = 1'b0;
        n_chk++;
        if (bus.frame_err !== 1'b1)
          $display("FAIL abort_err got=%b want=1", bus.frame_err);
        else n_pass++;
        n_chk++;
        if (got() !== last_vec)
          $display("FAIL abort_hold got=%h want=%h", got(), last_vec);
        else n_pass++;
      end
      if (n > 0) begin
        while ($urandom_range(99) < gap_pct) begin
          bus.pix_valid = 1'b0;
          bus.sof = 1'($urandom);
          bus.object_image = 1'($urandom);
          @(negedge clk);
        end
      end
      bus.sof = (idx == 0);
      if (abort_at > 0 && n == abort_at) begin
        bus.sof = 1'b1;
        idx = 0;
        model_clear();
        chk_err = 1'b1;
      end
      on = pix_on(mode, idx % W, idx / W);
      bus.pix_valid = 1'b1;
      bus.object_image = on;
      if (on) model_add(idx % W, idx / W);
      idx++;
      n++;
    end
  endtask

  task automatic test_reset();
    int r0;
    int f0;
    idle();
    #2 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bus.pix_valid = 1'($urandom);
      bus.sof = 1'($urandom);
      bus.object_image = 1'($urandom);
    end
    @(negedge clk);
    n_chk++;
    if (got() !== RST_VEC)
      $display("FAIL reset_vals got=%h want=%h", got(), RST_VEC);
    else n_pass++;
    n_chk++;
    if (bus.result_valid !== 1'b0)
      $display("FAIL reset_rv got=%b want=0", bus.result_valid);
    else n_pass++;
    n_chk++;
    if (bus.frame_err !== 1'b0)
      $display("FAIL reset_fe got=%b want=0", bus.frame_err);
    else n_pass++;
    rst = 1'b1;
    r0 = rv_cnt;
    f0 = fe_cnt;
    repeat (300) begin
      bus.pix_valid = 1'b1;
      bus.sof = 1'b0;
      bus.object_image = 1'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < 2000; i++) begin
      bus.pix_valid = 1'b1;
      bus.sof = (i == 0);
      bus.object_image = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) begin
      bus.pix_valid = 1'b1;
      bus.sof = 1'b0;
      bus.object_image = 1'($urandom);
      @(negedge clk);
    end
    idle();
    settle();
    n_chk++;
    if (rv_cnt - r0 != 0 || fe_cnt - f0 != 0)
      $display("FAIL reset_quiet got rv=%0d fe=%0d want 0/0",
               rv_cnt - r0, fe_cnt - f0);
    else n_pass++;
    n_chk++;
    if (got() !== RST_VEC)
      $display("FAIL reset_hold got=%h want=%h", got(), RST_VEC);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int r0;
    @(negedge clk);
    r0 = rv_cnt;
    send_frame(0, 0, 0, 1'b0);
    @(negedge clk);
    n_chk++;
    if (bus.result_valid !== 1'b1)
      $display("FAIL zero_rv got=%b want=1", bus.result_valid);
    else n_pass++;
    n_chk++;
    if (got() !== want())
      $display("FAIL zero_model got=%h want=%h", got(), want());
    else n_pass++;
    n_chk++;
    if (got() !== RST_VEC)
      $display("FAIL zero_const got=%h want=%h", got(), RST_VEC);
    else n_pass++;
    last_vec = want();
    send_frame(1, 0, 0, 1'b1);
    @(negedge clk);
    n_chk++;
    if (bus.result_valid !== 1'b1)
      $display("FAIL block_rv got=%b want=1", bus.result_valid);
    else n_pass++;
    n_chk++;
    if (got() !== want())
      $display("FAIL block_model got=%h want=%h", got(), want());
    else n_pass++;
    n_chk++;
    if (got() !== BLOCK_VEC)
      $display("FAIL block_const got=%h want=%h", got(), BLOCK_VEC);
    else n_pass++;
    last_vec = want();
    idle();
    @(negedge clk);
    n_chk++;
    if (bus.result_valid !== 1'b0)
      $display("FAIL rv_pulse got=%b want=0", bus.result_valid);
    else n_pass++;
    settle();
    n_chk++;
    if (rv_cnt - r0 != 2)
      $display("FAIL b2b_count got=%0d want=2", rv_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_single_gaps();
    send_frame(2, 3, 0, 1'b0);
    @(negedge clk);
    n_chk++;
    if (bus.result_valid !== 1'b1)
      $display("FAIL single_rv got=%b want=1", bus.result_valid);
    else n_pass++;
    n_chk++;
    if (got() !== want())
      $display("FAIL single_model got=%h want=%h", got(), want());
    else n_pass++;
    n_chk++;
    if (got() !== SINGLE_VEC)
      $display("FAIL single_const got=%h want=%h", got(), SINGLE_VEC);
    else n_pass++;
    last_vec = want();
    idle();
  endtask

  task automatic test_abort();
    int r0;
    int f0;
    @(negedge clk);
    r0 = rv_cnt;
    f0 = fe_cnt;
    send_frame(3, 0, 5000, 1'b0);
    @(negedge clk);
    n_chk++;
    if (bus.result_valid !== 1'b1)
      $display("FAIL abort_rv got=%b want=1", bus.result_valid);
    else n_pass++;
    n_chk++;
    if (got() !== want())
      $display("FAIL abort_model got=%h want=%h", got(), want());
    else n_pass++;
    idle();
    settle();
    n_chk++;
    if (rv_cnt - r0 != 1)
      $display("FAIL abort_rv_count got=%0d want=1", rv_cnt - r0);
    else n_pass++;
    n_chk++;
    if (fe_cnt - f0 != 1)
      $display("FAIL abort_fe_count got=%0d want=1", fe_cnt - f0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_gaps();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mask_profiler.md
# mask_profiler

Consumes the 1-bit object image stream produced by the skin/background segmentation stage, one pixel per valid cycle in raster order, and reduces each frame to the hand's bounding box, pixel count and coordinate sums. Sits directly downstream of segmentation, upstream of the gesture classifier. It holds per-frame accumulators only, never a frame buffer.

## Interface
Parameters:
- IMG_W, 160, pixels per line
- IMG_H, 120, lines per frame
- MIN_PIX, 64, minimum object pixels for a frame to count as non-empty

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- object_image  in  1  mask pixel, 1 = object
- pix_valid  in  1  object_image valid this cycle
- sof  in  1  first pixel of a frame; qualified by pix_valid
- min_x, max_x  out  8  bounding box columns
- min_y, max_y  out  7  bounding box rows
- pix_count  out  15  object pixels in frame
- sum_x, sum_y  out  22  sums of object pixel columns / rows
- obj_present  out  1  pix_count >= MIN_PIX
- result_valid  out  1  one-cycle pulse: all result outputs updated
- frame_err  out  1  one-cycle pulse: frame aborted by early sof

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: pixels ignored until pix_valid & sof. That pixel is (x=0, y=0). Accumulators load from it, and the state moves to ACCUM.
- ACCUM: each pix_valid advances x. At x = IMG_W-1, x wraps to 0 and y increments. The pixel at (IMG_W-1, IMG_H-1) is the last one, and accepting it moves the state to DONE.
- Per object pixel (object_image=1): min_x/max_x/min_y/max_y update, pix_count += 1, sum_x += x, sum_y += y.
- Running box reset values: min = all-ones, max = 0. Every frame's first pixel loads these before its own contribution.
- DONE, one cycle: registers results to outputs, pulses result_valid, returns to IDLE. A pix_valid & sof arriving in the DONE cycle starts the next frame; accumulators load from it and the state goes to ACCUM.
- Empty frame (pix_count = 0): outputs min_x=255, min_y=127, max_x=0, max_y=0, obj_present=0. Downstream treats min>max as no box.
- pix_valid & sof in ACCUM before the last pixel: frame_err pulses, the partial frame is discarded (outputs unchanged, no result_valid), and accumulation restarts from this pixel at (0,0).
- pix_valid low: all state holds, no counting.
- Widths: pix_count saturates-free (max 19200 < 2^15). sum_x max 3 052 800, sum_y max 2 284 800, both < 2^22. No overflow is possible at default parameters. Derive widths with $clog2 of the parameters.

## Timing
- Reset (rst low, async): state IDLE, x=y=0. All result outputs are 0, except min_x=255 and min_y=127. result_valid, frame_err and obj_present are 0.
- Latency: result_valid is high the cycle after the last pixel is accepted. Outputs are stable from that edge until the next result_valid.
- frame_err is high the cycle after the offending sof.
- Throughput: one pixel per clock sustained, no stall output.
- Reset released mid-frame: the block waits for the next sof.

## Structure
- Shared package `gesture_pkg`: IMG_W/IMG_H defaults, coordinate and sum width localparams, state enum (IDLE/ACCUM/DONE).
- One sub-module `raster_counter`: x/y counters with pix_valid enable, sof clear and last-pixel flag. It is reused by later line-based blocks.
- Accumulators and FSM live in mask_profiler.

## Test plan
- Reset: hold rst low mid-stream, then release -> all outputs at reset values; nothing is produced until the next sof.
- All-zero frame of 19200 valid pixels -> result_valid one cycle after the last pixel; pix_count=0, min_x=255, max_x=0, obj_present=0.
- 10x10 block at x 40..49, y 30..39 -> min_x=40, max_x=49, min_y=30, max_y=39, pix_count=100, sum_x=4450, sum_y=3450, obj_present=1.
- Single pixel at (159,119) with random pix_valid gaps -> box (159,159,119,119), pix_count=1, obj_present=0. The result still arrives one cycle after the last pixel.
- sof reasserted at pixel 5000 -> frame_err pulses, with no result_valid for the aborted frame. The next full frame reports correctly.
- Back-to-back frames with sof in the DONE cycle -> both frames reported, with no pixel lost.
